dual_port_ram_be: RTL and testbench
===================================

// Module: dual_port_ram_be
// PURPOSE
//   Simple dual-port RAM: one write port and one independent read port, both on clk.
//   Adds per-lane write masks, selectable read-during-write policy and an optional output register.
//   Adds a post-reset clear sequencer that zeroes the whole array.
//   Used for frame/line buffers and register files where a producer and a consumer access memory concurrently.
// PARAMETERS
//   SIZE         8   word width in bits; must be a multiple of BYTE_W
//   DEPTH        16  number of words, >=2; need not be a power of 2
//   BYTE_W       8   write-mask lane width; LANES = SIZE/BYTE_W
//   RD_MODE      0   same-address collision: 0 = old data (read-first), 1 = new data (write-first)
//   OUT_REG      0   1 = extra output register stage; read latency becomes 2
//   CLEAR_ON_RST 1   1 = zero every word after reset; 0 = array contents undefined after reset
// PORTS
//   clk            in   1              clock; all logic on rising edge
//   rst            in   1              reset; synchronous, active-high
//   busy           out  1              1 while the clear sequence runs; ports are ignored
//   write_address  in   $clog2(DEPTH)  word address to write
//   write_data     in   SIZE           data to write
//   write_mask     in   LANES          lane i written only when write_mask[i]=1
//   write_en       in   1              write request
//   read_address   in   $clog2(DEPTH)  word address to read
//   read_en        in   1              read request
//   read_data      out  SIZE           read result; holds its value until the next valid read
//   read_valid     out  1              1-cycle pulse: read_data carries a new result
// BEHAVIOUR
//   Reset values:
//     - read_data = 0, read_valid = 0, pipeline valid bits = 0.
//     - busy = CLEAR_ON_RST; clear counter = 0.
//   Clear state machine (states CLEAR, RUN):
//     - rst forces CLEAR when CLEAR_ON_RST=1, otherwise RUN.
//     - In CLEAR, one word is zeroed per cycle at address 0..DEPTH-1 (all lanes).
//     - busy=1 for exactly DEPTH cycles after rst falls, then RUN; busy=0 from then on.
//     - In CLEAR, write_en and read_en are ignored and read_valid stays 0.
//     - rst asserted mid-clear restarts the clear at address 0.
//   Write (RUN): on an edge with write_en=1, for each lane i with write_mask[i]=1,
//     ram[write_address][i*BYTE_W +: BYTE_W] <= write_data lane i. Unmasked lanes are unchanged.
//   Read (RUN): read_en=1 at edge N.
//     - OUT_REG=0: read_data updates and read_valid=1 after edge N+1, i.e. during cycle N+1.
//     - OUT_REG=1: same, one cycle later (cycle N+2).
//     - Back-to-back reads give one result per cycle with no bubbles.
//   Collision: write_en and read_en in the same cycle with write_address==read_address.
//     - RD_MODE=0: the read returns the word as it was before the write.
//     - RD_MODE=1: the read returns the merged word (masked lanes new, other lanes old).
//   Out of range (address >= DEPTH, only possible when DEPTH is not a power of 2):
//     - Write is dropped with no side effect.
//     - Read completes normally with read_data = 0 and read_valid = 1.
//   rst during a read in flight: the pending read_valid is cancelled; read_data returns to 0.
//   write_mask = 0 with write_en = 1 is a legal no-op.
// TESTING
//   1. Reset, DEPTH=16, CLEAR_ON_RST=1 -> busy=1 for 16 cycles, then 0; reading all addresses returns 0x00.
//   2. Write 0xA5 @3, then read @3 at cycle N -> read_data=0xA5 with read_valid=1 at N+1 (N+2 if OUT_REG=1).
//   3. SIZE=16, mem@5=0x1234; write 0xABCD mask=2'b10 @5; read @5 -> 0xAB34.
//   4. mem@7=0x11; same-cycle write 0x22 and read @7 -> RD_MODE=0 returns 0x11, RD_MODE=1 returns 0x22;
//      a following read returns 0x22 in both modes.
//   5. rst pulsed at clear cycle 9 -> busy stays 1 for a full 16 cycles after rst falls; all words read 0.
//   6. DEPTH=12: write 0xFF @13 then read @13 and @0 -> 0x00 both; consecutive reads @0..11 return one valid per cycle.

Source files
------------

// File: rtl/dual_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module  : dual_port_ram_be
// Purpose : Simple dual-port RAM with per-lane write masks, selectable
//           read-during-write policy, optional output register and a
//           post-reset clear sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module dual_port_ram_be #(
  parameter int SIZE         = 8,
  parameter int DEPTH        = 16,
  parameter int BYTE_W       = 8,
  parameter int RD_MODE      = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1,
  localparam int LANES       = SIZE / BYTE_W,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic [AW-1:0]     write_address,
  input  logic [SIZE-1:0]   write_data,
  input  logic [LANES-1:0]  write_mask,
  input  logic              write_en,
  input  logic [AW-1:0]     read_address,
  input  logic              read_en,
  output logic [SIZE-1:0]   read_data,
  output logic              read_valid
);

  localparam logic [0:0]    c_st_clear  = 1'b0;
  localparam logic [0:0]    c_st_run    = 1'b1;
  localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [SIZE-1:0] mem [DEPTH];

  logic            w_run;
  logic            w_wr_ok;
  logic            w_rd_ok;
  logic            w_rd_in_range;
  logic            w_collision;
  logic [SIZE-1:0] w_bit_mask;
  logic [SIZE-1:0] w_mem_word;
  logic [SIZE-1:0] w_merged;
  logic [SIZE-1:0] w_rd_word;
  logic            rd_valid_q;
  logic [SIZE-1:0] rd_data_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RST != 0) ? c_st_clear : c_st_run;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic: walk the clear pointer once through the array
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == c_st_clear) begin
      if (clr_cnt_q == c_last_addr) begin
        state_d = c_st_run;
      end else begin
        clr_cnt_d = clr_cnt_q + AW'(1);
      end
    end
  end

  // Output logic
  always_comb begin
    busy  = (state_q == c_st_clear);
    w_run = (state_q == c_st_run);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_bit_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{write_mask[i]}};
  end

  always_comb begin
    w_wr_ok       = w_run && !rst && write_en && ({1'b0, write_address} < c_depth);
    w_rd_ok       = w_run && read_en;
    w_rd_in_range = ({1'b0, read_address} < c_depth);
    w_collision   = w_wr_ok && (write_address == read_address);
    w_mem_word    = mem[read_address];
    w_merged      = (write_data & w_bit_mask) | (w_mem_word & ~w_bit_mask);
    w_rd_word     = '0;
    if (w_rd_in_range) begin
      w_rd_word = ((RD_MODE != 0) && w_collision) ? w_merged : w_mem_word;
    end
  end

  // Array is not reset; the clear sequencer zeroes it one word per cycle
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt_q] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (write_mask[i]) begin
          mem[write_address][i*BYTE_W +: BYTE_W] <= write_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= w_rd_ok;
      if (w_rd_ok) begin
        rd_data_q <= w_rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic            out_valid_q;
    logic [SIZE-1:0] out_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          out_data_q <= rd_data_q;
        end
      end
    end

    assign read_valid = out_valid_q;
    assign read_data  = out_data_q;
  end else begin : g_no_out_reg
    assign read_valid = rd_valid_q;
    assign read_data  = rd_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_be.sv
`default_nettype none
// ============================================================================
// Module  : tb_dual_port_ram_be
// Purpose : Two RAM configurations driven by shared stimulus and checked
//           against a behavioural array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  write_address;
  logic [15:0] write_data;
  logic [1:0]  write_mask;
  logic        write_en;
  logic [3:0]  read_address;
  logic        read_en;
  logic        busy_a, busy_b, rv_a, rv_b;
  logic [15:0] rd_a, rd_b;

  always #5 clk = ~clk;

  // A: 12 words, read-first, no output register
  dual_port_ram_be #(.SIZE(16), .DEPTH(12), .BYTE_W(8), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)) u_dut_a (
    .clk(clk), .rst(rst), .busy(busy_a),
    .write_address(write_address), .write_data(write_data), .write_mask(write_mask), .write_en(write_en),
    .read_address(read_address), .read_en(read_en), .read_data(rd_a), .read_valid(rv_a));

  // B: 16 words, write-first, output register
  dual_port_ram_be #(.SIZE(16), .DEPTH(16), .BYTE_W(8), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)) u_dut_b (
    .clk(clk), .rst(rst), .busy(busy_b),
    .write_address(write_address), .write_data(write_data), .write_mask(write_mask), .write_en(write_en),
    .read_address(read_address), .read_en(read_en), .read_data(rd_b), .read_valid(rv_b));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mdl_a [16];
  logic [15:0] mdl_b [16];
  logic        exp_va, exp_vb, pend_vb;
  logic [15:0] exp_da, exp_db, pend_db;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
    exp_va = 0; exp_vb = 0; pend_vb = 0;
    exp_da = '0; exp_db = '0; pend_db = '0;
  endtask

  // One clock of stimulus; the model decides what each RAM must return.
  task automatic cycle(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] wm, input logic re, input logic [3:0] ra);
    logic [15:0] bm, va, vb, new_a, new_b;
    write_en = we; write_address = wa; write_data = wd; write_mask = wm;
    read_en = re; read_address = ra;
    bm    = {{8{wm[1]}}, {8{wm[0]}}};
    new_a = (wd & bm) | (mdl_a[wa] & ~bm);
    new_b = (wd & bm) | (mdl_b[wa] & ~bm);
    va    = (ra < 12) ? mdl_a[ra] : 16'h0000;
    vb    = (we && wa == ra) ? new_b : mdl_b[ra];
    if (we && wa < 12) mdl_a[wa] = new_a;
    if (we) mdl_b[wa] = new_b;
    @(posedge clk); #1;
    exp_va = re;
    if (re) exp_da = va;
    exp_vb = pend_vb;
    if (pend_vb) exp_db = pend_db;
    pend_vb = re;
    pend_db = vb;
  endtask

  task automatic drive_junk(input logic en);
    write_en = en; read_en = en;
    write_address = 4'($urandom); read_address = 4'($urandom);
    write_data = 16'($urandom) | 16'h0001; write_mask = 2'b11;
  endtask

  task automatic test_clear(input bit fill, input int restart_at);
    int na, nb, nv;
    if (fill) begin
      for (int a = 0; a < 16; a++) cycle(1, 4'(a), 16'($urandom) | 16'h0101, 2'b11, 0, 0);
    end
    rst = 1; write_en = 0; read_en = 0;
    @(posedge clk); #1;
    model_clear();
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rst_busy_a: got %b want 1", busy_a); end
    n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL rst_busy_b: got %b want 1", busy_b); end
    n_checks++; if (rv_a !== 1'b0 || rd_a !== 16'h0) begin n_fail++; $display("FAIL rst_out_a: valid %b data %h want 0/0000", rv_a, rd_a); end
    n_checks++; if (rv_b !== 1'b0 || rd_b !== 16'h0) begin n_fail++; $display("FAIL rst_out_b: valid %b data %h want 0/0000", rv_b, rd_b); end
    rst = 0;
    if (restart_at > 0) begin
      repeat (restart_at) begin drive_junk(1); @(posedge clk); #1; end
      rst = 1; write_en = 0; read_en = 0;
      @(posedge clk); #1;
      rst = 0;
    end
    na = 0; nb = 0; nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      if (rv_a || rv_b) nv++;
      drive_junk(busy_a);
      @(posedge clk); #1;
    end
    write_en = 0; read_en = 0;
    n_checks++; if (na != 12) begin n_fail++; $display("FAIL busy_len_a: got %0d cycles want 12", na); end
    n_checks++; if (nb != 16) begin n_fail++; $display("FAIL busy_len_b: got %0d cycles want 16", nb); end
    n_checks++; if (nv != 0) begin n_fail++; $display("FAIL clear_valid: got %0d valid pulses want 0", nv); end
    for (int a = 0; a <= 16; a++) begin
      cycle(0, 0, 0, 0, (a < 16), 4'(a));
      n_checks++; if (rv_a !== exp_va) begin n_fail++; $display("FAIL clr_rd_valid_a @%0d: got %b want %b", a, rv_a, exp_va); end
      n_checks++; if (rd_a !== exp_da) begin n_fail++; $display("FAIL clr_rd_data_a @%0d: got %h want %h", a, rd_a, exp_da); end
      n_checks++; if (rv_b !== exp_vb) begin n_fail++; $display("FAIL clr_rd_valid_b @%0d: got %b want %b", a, rv_b, exp_vb); end
      n_checks++; if (rd_b !== exp_db) begin n_fail++; $display("FAIL clr_rd_data_b @%0d: got %h want %h", a, rd_b, exp_db); end
    end
  endtask

  task automatic test_basic();
    cycle(1, 3, 16'h00A5, 2'b11, 0, 0);
    cycle(0, 0, 0, 0, 1, 3);
    n_checks++; if (rv_a !== 1'b1 || rd_a !== 16'h00A5) begin n_fail++; $display("FAIL basic_a: valid %b data %h want 1/00a5", rv_a, rd_a); end
    n_checks++; if (rv_b !== 1'b0) begin n_fail++; $display("FAIL basic_b_early: valid %b want 0", rv_b); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (rv_a !== 1'b0 || rd_a !== 16'h00A5) begin n_fail++; $display("FAIL basic_a_hold: valid %b data %h want 0/00a5", rv_a, rd_a); end
    n_checks++; if (rv_b !== 1'b1 || rd_b !== 16'h00A5) begin n_fail++; $display("FAIL basic_b: valid %b data %h want 1/00a5", rv_b, rd_b); end
  endtask

  task automatic test_mask();
    cycle(1, 5, 16'h1234, 2'b11, 0, 0);
    cycle(1, 5, 16'hABCD, 2'b10, 0, 0);
    cycle(1, 5, 16'hFFFF, 2'b00, 0, 0);
    cycle(0, 0, 0, 0, 1, 5);
    n_checks++; if (rv_a !== 1'b1 || rd_a !== 16'hAB34) begin n_fail++; $display("FAIL mask_a: valid %b data %h want 1/ab34", rv_a, rd_a); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (rv_b !== 1'b1 || rd_b !== 16'hAB34) begin n_fail++; $display("FAIL mask_b: valid %b data %h want 1/ab34", rv_b, rd_b); end
  endtask

  task automatic test_collision();
    cycle(1, 7, 16'h0011, 2'b11, 0, 0);
    cycle(1, 7, 16'h0022, 2'b11, 1, 7);
    n_checks++; if (rv_a !== 1'b1 || rd_a !== 16'h0011) begin n_fail++; $display("FAIL coll_old_a: valid %b data %h want 1/0011", rv_a, rd_a); end
    cycle(0, 0, 0, 0, 1, 7);
    n_checks++; if (rv_b !== 1'b1 || rd_b !== 16'h0022) begin n_fail++; $display("FAIL coll_new_b: valid %b data %h want 1/0022", rv_b, rd_b); end
    n_checks++; if (rv_a !== 1'b1 || rd_a !== 16'h0022) begin n_fail++; $display("FAIL coll_after_a: valid %b data %h want 1/0022", rv_a, rd_a); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (rv_b !== 1'b1 || rd_b !== 16'h0022) begin n_fail++; $display("FAIL coll_after_b: valid %b data %h want 1/0022", rv_b, rd_b); end
  endtask

  task automatic test_out_of_range();
    cycle(1, 13, 16'h00FF, 2'b11, 0, 0);
    cycle(0, 0, 0, 0, 1, 13);
    n_checks++; if (rv_a !== 1'b1 || rd_a !== 16'h0000) begin n_fail++; $display("FAIL oor_rd13_a: valid %b data %h want 1/0000", rv_a, rd_a); end
    cycle(0, 0, 0, 0, 1, 0);
    n_checks++; if (rv_a !== 1'b1 || rd_a !== 16'h0000) begin n_fail++; $display("FAIL oor_rd0_a: valid %b data %h want 1/0000", rv_a, rd_a); end
    n_checks++; if (rv_b !== 1'b1 || rd_b !== 16'h00FF) begin n_fail++; $display("FAIL oor_rd13_b: valid %b data %h want 1/00ff", rv_b, rd_b); end
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 12; a++) cycle(1, 4'(a), 16'h5A00 + 16'(a * 17), 2'b11, 0, 0);
    for (int a = 0; a <= 12; a++) begin
      cycle(0, 0, 0, 0, (a < 12), 4'(a));
      n_checks++; if (rv_a !== exp_va) begin n_fail++; $display("FAIL b2b_valid_a @%0d: got %b want %b", a, rv_a, exp_va); end
      n_checks++; if (rd_a !== exp_da) begin n_fail++; $display("FAIL b2b_data_a @%0d: got %h want %h", a, rd_a, exp_da); end
      n_checks++; if (rv_b !== exp_vb) begin n_fail++; $display("FAIL b2b_valid_b @%0d: got %b want %b", a, rv_b, exp_vb); end
      n_checks++; if (rd_b !== exp_db) begin n_fail++; $display("FAIL b2b_data_b @%0d: got %h want %h", a, rd_b, exp_db); end
    end
  endtask

  task automatic test_random();
    logic [3:0] wa, ra;
    for (int i = 0; i < 300; i++) begin
      wa = 4'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      cycle(1'($urandom), wa, 16'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), ra);
      n_checks++; if (rv_a !== exp_va) begin n_fail++; $display("FAIL rand_valid_a #%0d: got %b want %b", i, rv_a, exp_va); end
      n_checks++; if (rd_a !== exp_da) begin n_fail++; $display("FAIL rand_data_a #%0d: got %h want %h", i, rd_a, exp_da); end
      n_checks++; if (rv_b !== exp_vb) begin n_fail++; $display("FAIL rand_valid_b #%0d: got %b want %b", i, rv_b, exp_vb); end
      n_checks++; if (rd_b !== exp_db) begin n_fail++; $display("FAIL rand_data_b #%0d: got %h want %h", i, rd_b, exp_db); end
    end
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rst_in_flight();
    int n;
    cycle(1, 2, 16'hBEEF, 2'b11, 0, 0);
    cycle(0, 0, 0, 0, 1, 2);
    n_checks++; if (rv_a !== 1'b1 || rd_a !== 16'hBEEF) begin n_fail++; $display("FAIL flight_pre_a: valid %b data %h want 1/beef", rv_a, rd_a); end
    rst = 1; read_en = 0; write_en = 0;
    @(posedge clk); #1;
    model_clear();
    n_checks++; if (rv_a !== 1'b0 || rd_a !== 16'h0) begin n_fail++; $display("FAIL flight_cancel_a: valid %b data %h want 0/0000", rv_a, rd_a); end
    n_checks++; if (rv_b !== 1'b0 || rd_b !== 16'h0) begin n_fail++; $display("FAIL flight_cancel_b: valid %b data %h want 0/0000", rv_b, rd_b); end
    rst = 0;
    n = 0;
    while ((busy_a || busy_b) && n < 40) begin @(posedge clk); #1; n++; end
    n_checks++; if (busy_a || busy_b) begin n_fail++; $display("FAIL flight_busy_timeout: busy %b/%b after %0d cycles want 0/0", busy_a, busy_b, n); end
  endtask

  initial begin
    rst = 1; write_en = 0; read_en = 0;
    write_address = '0; read_address = '0; write_data = '0; write_mask = '0;
    model_clear();
    test_clear(0, -1);
    test_basic();
    test_mask();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_clear(1, -1);
    test_clear(1, 9);
    test_rst_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
